// File: rtl/sprite_engine.sv
// Sprite pixel engine: tear-free shadowed position, frame-indexed ROM addressing,
// static/loop/one-shot animation and invincibility blink, 2-cycle pixel latency.
module sprite_engine #(
    parameter  int X_W        = 10,
    parameter  int Y_W        = 10,
    parameter  int SPR_X_SIZE = 64,
    parameter  int SPR_Y_SIZE = 64,
    parameter  int FRAMES     = 4,
    parameter  int FRAME_HOLD = 8,
    parameter  int BLINK_HALF = 16,
    parameter  int GRAY_W     = 4,
    localparam int ADDR_W     = $clog2(FRAMES * SPR_X_SIZE * SPR_Y_SIZE),
    localparam int FRAME_W    = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic                  clk_vga,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  v_sync_i,
    input  logic [X_W-1:0]        req_x_addr_i,
    input  logic [Y_W-1:0]        req_y_addr_i,
    input  logic [X_W-1:0]        x_pos_i,
    input  logic [Y_W-1:0]        y_pos_i,
    input  logic [1:0]            mode_i,
    input  logic                  anim_start_i,
    input  logic                  blink_i,
    output logic                  rom_en_o,
    output logic [ADDR_W-1:0]     rom_addr_o,
    input  logic [GRAY_W:0]       rom_data_i,
    output logic [3*GRAY_W-1:0]   vga_rgb_o,
    output logic                  vga_alpha_o,
    output logic [FRAME_W-1:0]    frame_o,
    output logic                  busy_o,
    output logic                  anim_done_o
);

    localparam int HOLD_W    = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int BLINK_W   = $clog2(2 * BLINK_HALF);
    localparam int FRAME_PIX = SPR_X_SIZE * SPR_Y_SIZE;

    localparam logic [1:0] MODE_LOOP    = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    logic                 vs_r;
    logic                 tick_s;
    logic [X_W-1:0]       sx_r;
    logic [Y_W-1:0]       sy_r;
    logic [1:0]           mode_r;

    logic [1:0]           state_r, state_nxt_s;
    logic [FRAME_W-1:0]   frame_r, frame_nxt_s;
    logic [HOLD_W-1:0]    hold_r, hold_nxt_s;
    logic                 done_nxt_s;
    logic                 adv_s;

    logic [BLINK_W-1:0]   blink_cnt_r;
    logic                 hide_s;

    logic [X_W:0]         x_end_s;
    logic [Y_W:0]         y_end_s;
    logic [X_W-1:0]       dx_s;
    logic [Y_W-1:0]       dy_s;
    logic                 hit_s;
    logic [ADDR_W-1:0]    addr_s;
    logic                 valid_r;

    assign tick_s = vs_r & ~v_sync_i;
    assign adv_s  = tick_s & (hold_r == HOLD_W'(FRAME_HOLD - 1));

    // Animation next-state: hold counter, frame index and one-shot sequencing
    always_comb begin
        state_nxt_s = state_r;
        frame_nxt_s = frame_r;
        done_nxt_s  = 1'b0;
        if (adv_s) begin
            hold_nxt_s = {HOLD_W{1'b0}};
        end else if (tick_s) begin
            hold_nxt_s = hold_r + HOLD_W'(1);
        end else begin
            hold_nxt_s = hold_r;
        end

        if (!en_i) begin
            state_nxt_s = ST_IDLE;
            frame_nxt_s = {FRAME_W{1'b0}};
            hold_nxt_s  = {HOLD_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if ((mode_r == MODE_ONESHOT) && anim_start_i) begin
                        state_nxt_s = ST_RUN;
                        frame_nxt_s = {FRAME_W{1'b0}};
                        hold_nxt_s  = {HOLD_W{1'b0}};
                    end else if (mode_r == MODE_LOOP) begin
                        if (adv_s) begin
                            frame_nxt_s = (frame_r == FRAME_W'(FRAMES - 1)) ?
                                          {FRAME_W{1'b0}} : frame_r + FRAME_W'(1);
                        end else begin
                            frame_nxt_s = frame_r;
                        end
                    end else if (mode_r == MODE_ONESHOT) begin
                        // Idle one-shot keeps showing whatever frame the last run ended on
                        frame_nxt_s = frame_r;
                    end else begin
                        frame_nxt_s = {FRAME_W{1'b0}};
                        hold_nxt_s  = {HOLD_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    if (mode_r != MODE_ONESHOT) begin
                        state_nxt_s = ST_IDLE;
                    end else if (adv_s) begin
                        if (frame_r == FRAME_W'(FRAMES - 1)) begin
                            state_nxt_s = ST_DONE;
                            done_nxt_s  = 1'b1;
                        end else begin
                            frame_nxt_s = frame_r + FRAME_W'(1);
                        end
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    frame_nxt_s = {FRAME_W{1'b0}};
                    hold_nxt_s  = {HOLD_W{1'b0}};
                end
            endcase
        end
    end

    // Hit test and ROM address; sums are one bit wider so an off-screen edge never wraps
    always_comb begin
        x_end_s = {1'b0, sx_r} + (X_W + 1)'(SPR_X_SIZE);
        y_end_s = {1'b0, sy_r} + (Y_W + 1)'(SPR_Y_SIZE);
        dx_s    = req_x_addr_i - sx_r;
        dy_s    = req_y_addr_i - sy_r;
        hide_s  = blink_i & (blink_cnt_r >= BLINK_W'(BLINK_HALF));
        hit_s   = en_i
                & (req_x_addr_i >= sx_r) & ({1'b0, req_x_addr_i} < x_end_s)
                & (req_y_addr_i >= sy_r) & ({1'b0, req_y_addr_i} < y_end_s)
                & ~hide_s;
        addr_s  = ADDR_W'(frame_r) * ADDR_W'(FRAME_PIX)
                + ADDR_W'(dy_s) * ADDR_W'(SPR_X_SIZE)
                + ADDR_W'(dx_s);
    end

    // Frame tick detection and shadow copy of position/mode
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            vs_r   <= 1'b0;
            sx_r   <= {X_W{1'b0}};
            sy_r   <= {Y_W{1'b0}};
            mode_r <= 2'b00;
        end else begin
            vs_r <= v_sync_i;
            if (tick_s) begin
                sx_r   <= x_pos_i;
                sy_r   <= y_pos_i;
                mode_r <= mode_i;
            end
        end
    end

    // Animation state registers and handshake outputs
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            frame_r     <= {FRAME_W{1'b0}};
            hold_r      <= {HOLD_W{1'b0}};
            busy_o      <= 1'b0;
            anim_done_o <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            frame_r     <= frame_nxt_s;
            hold_r      <= hold_nxt_s;
            busy_o      <= (state_nxt_s == ST_RUN);
            anim_done_o <= done_nxt_s;
        end
    end

    // Blink phase counter, running only while blinking is requested
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            blink_cnt_r <= {BLINK_W{1'b0}};
        end else if (!blink_i) begin
            blink_cnt_r <= {BLINK_W{1'b0}};
        end else if (tick_s) begin
            blink_cnt_r <= (blink_cnt_r == BLINK_W'(2 * BLINK_HALF - 1)) ?
                           {BLINK_W{1'b0}} : blink_cnt_r + BLINK_W'(1);
        end
    end

    // ROM fetch stage and pixel-valid pipeline
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            rom_en_o   <= 1'b0;
            rom_addr_o <= {ADDR_W{1'b0}};
            valid_r    <= 1'b0;
        end else begin
            rom_en_o <= hit_s;
            if (hit_s) begin
                rom_addr_o <= addr_s;
            end
            valid_r <= rom_en_o & en_i;
        end
    end

    assign frame_o     = frame_r;
    assign vga_alpha_o = valid_r & rom_data_i[0];
    assign vga_rgb_o   = vga_alpha_o ? {3{rom_data_i[GRAY_W:1]}} : {(3 * GRAY_W){1'b0}};

endmodule

// File: tb/tb_sprite_engine.sv
// Randomized scoreboard bench for sprite_engine with a frame/tick-level reference model.
module tb_sprite_engine;

    localparam int FRAMES = 4;
    localparam int FH     = 2;
    localparam int BH     = 2;
    localparam int SX     = 64;
    localparam int SY     = 64;

    logic        clk_vga = 1'b0;
    logic        rst = 1'b1;
    logic        en_i = 1'b0;
    logic        v_sync_i = 1'b1;
    logic [9:0]  req_x_addr_i = 10'd0;
    logic [9:0]  req_y_addr_i = 10'd0;
    logic [9:0]  x_pos_i = 10'd0;
    logic [9:0]  y_pos_i = 10'd0;
    logic [1:0]  mode_i = 2'b00;
    logic        anim_start_i = 1'b0;
    logic        blink_i = 1'b0;
    logic        rom_en_o;
    logic [13:0] rom_addr_o;
    logic [4:0]  rom_data_i = 5'h00;
    logic [11:0] vga_rgb_o;
    logic        vga_alpha_o;
    logic [1:0]  frame_o;
    logic        busy_o;
    logic        anim_done_o;

    sprite_engine #(
        .X_W(10), .Y_W(10), .SPR_X_SIZE(SX), .SPR_Y_SIZE(SY),
        .FRAMES(FRAMES), .FRAME_HOLD(FH), .BLINK_HALF(BH), .GRAY_W(4)
    ) dut (
        .clk_vga(clk_vga), .rst(rst), .en_i(en_i), .v_sync_i(v_sync_i),
        .req_x_addr_i(req_x_addr_i), .req_y_addr_i(req_y_addr_i),
        .x_pos_i(x_pos_i), .y_pos_i(y_pos_i), .mode_i(mode_i),
        .anim_start_i(anim_start_i), .blink_i(blink_i),
        .rom_en_o(rom_en_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .vga_rgb_o(vga_rgb_o), .vga_alpha_o(vga_alpha_o), .frame_o(frame_o),
        .busy_o(busy_o), .anim_done_o(anim_done_o)
    );

    always #5 clk_vga = ~clk_vga;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk_vga) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic        rom_en;
        logic [13:0] addr;
        logic [1:0]  frame;
        logic        busy;
        logic        done;
    } ctl_t;

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic        alpha;
    } pix_t;

    ctl_t q_ctl[$];
    pix_t q_pix[$];
    ctl_t mc;
    pix_t mp;

    // Next-cycle values of the slow inputs, applied inside step()
    logic       nx_en = 1'b0;
    logic       nx_blink = 1'b0;
    logic [1:0] nx_mode = 2'b00;
    logic [9:0] nx_xpos = 10'd0;
    logic [9:0] nx_ypos = 10'd0;

    // Reference model state
    int         m_sx, m_sy;
    logic [1:0] m_mode;
    logic       m_vs_prev;
    int         m_frame, m_os_n, m_loop_n, m_nb, m_last_addr, m_prev_addr;
    logic       m_run, m_in_done, m_prev_hit;
    logic       rom_pend_en;
    logic [4:0] rom_pend;

    function automatic logic [4:0] rom_fn(input int a);
        return 5'h1F ^ 5'((a * 7) ^ (a >> 4));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sx = 0; m_sy = 0; m_mode = 2'b00; m_vs_prev = 1'b0;
        m_frame = 0; m_os_n = 0; m_loop_n = 0; m_nb = 0;
        m_last_addr = 0; m_prev_addr = 0;
        m_run = 1'b0; m_in_done = 1'b0; m_prev_hit = 1'b0;
        rom_pend_en = 1'b0; rom_pend = 5'h00; rom_data_i = 5'h00;
        q_ctl.delete();
        q_pix.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rom_en"},  32'(rom_en_o),    32'd0);
        check({tag, ".addr"},    32'(rom_addr_o),  32'd0);
        check({tag, ".rgb"},     32'(vga_rgb_o),   32'd0);
        check({tag, ".alpha"},   32'(vga_alpha_o), 32'd0);
        check({tag, ".frame"},   32'(frame_o),     32'd0);
        check({tag, ".busy"},    32'(busy_o),      32'd0);
        check({tag, ".done"},    32'(anim_done_o), 32'd0);
    endtask

    // One pixel clock: drive inputs, predict the response, advance the model
    task automatic step(input logic vs, input logic start, input int rx, input int ry);
        logic [4:0] d;
        logic       val, hit, hide, tick, done_nxt;
        pix_t       p;
        ctl_t       c;
        @(posedge clk_vga);
        #1;
        if (rom_pend_en) rom_data_i = rom_pend;
        rom_pend_en = rom_en_o;
        rom_pend    = rom_fn(int'(rom_addr_o));
        v_sync_i = vs; anim_start_i = start;
        req_x_addr_i = rx[9:0]; req_y_addr_i = ry[9:0];
        en_i = nx_en; blink_i = nx_blink; mode_i = nx_mode;
        x_pos_i = nx_xpos; y_pos_i = nx_ypos;

        val     = m_prev_hit & en_i;
        d       = rom_fn(m_prev_addr);
        p.due   = cyc + 1;
        p.alpha = val & d[0];
        p.rgb   = p.alpha ? {3{d[4:1]}} : 12'h000;
        q_pix.push_back(p);

        hide = blink_i && ((m_nb % (2 * BH)) >= BH);
        hit  = en_i && (rx >= m_sx) && (rx < m_sx + SX) && (ry >= m_sy) && (ry < m_sy + SY) && !hide;
        if (hit) m_last_addr = m_frame * SX * SY + (ry - m_sy) * SX + (rx - m_sx);

        tick = m_vs_prev && !vs;
        m_vs_prev = vs;
        done_nxt = 1'b0;
        if (!en_i) begin
            m_run = 1'b0; m_frame = 0; m_loop_n = 0;
        end else if (m_run) begin
            if (m_mode != 2'b10) begin
                m_run = 1'b0;
            end else if (tick) begin
                m_os_n++;
                if (m_os_n == FRAMES * FH) begin
                    m_run = 1'b0; done_nxt = 1'b1; m_frame = FRAMES - 1;
                end else begin
                    m_frame = m_os_n / FH;
                end
            end
        end else if (m_in_done) begin
            m_run = 1'b0;
        end else if (m_mode == 2'b10) begin
            if (start) begin
                m_run = 1'b1; m_os_n = 0; m_frame = 0;
            end
        end else if (m_mode == 2'b01) begin
            if (tick) m_loop_n++;
            m_frame = (m_loop_n / FH) % FRAMES;
        end else begin
            m_frame = 0; m_loop_n = 0;
        end
        m_in_done = done_nxt;

        if (!blink_i) m_nb = 0;
        else if (tick) m_nb++;

        if (tick) begin
            m_sx = int'(x_pos_i); m_sy = int'(y_pos_i); m_mode = mode_i;
        end

        c.due = cyc + 1; c.rom_en = hit; c.addr = 14'(m_last_addr);
        c.frame = 2'(m_frame); c.busy = m_run; c.done = done_nxt;
        q_ctl.push_back(c);
        m_prev_hit  = hit;
        m_prev_addr = m_last_addr;
    endtask

    task automatic step_rand(input logic vs, input logic start);
        int rx, ry;
        if ($urandom_range(0, 7) == 0) begin
            rx = int'($urandom_range(0, 1023));
            ry = int'($urandom_range(0, 1023));
        end else begin
            rx = (m_sx + int'($urandom_range(0, 71)) - 4) & 1023;
            ry = (m_sy + int'($urandom_range(0, 71)) - 4) & 1023;
        end
        step(vs, start, rx, ry);
    endtask

    // One video frame: v_sync low for 3 cycles, position moves mid-frame
    task automatic vframe(input int len, input int start_at);
        for (int i = 0; i < len; i++) begin
            if (i == len / 2) begin
                nx_xpos = 10'($urandom_range(0, 1023));
                nx_ypos = 10'($urandom_range(0, 1023));
            end
            step_rand(i >= 3, i == start_at);
        end
    endtask

    task automatic do_reset();
        @(posedge clk_vga);
        #1;
        rst = 1'b1; en_i = 1'b0; v_sync_i = 1'b1; anim_start_i = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        model_reset();
        repeat (2) @(posedge clk_vga);
        #1;
        rst = 1'b0;
        m_vs_prev = 1'b1;
    endtask

    // Scoreboard monitor
    always @(negedge clk_vga) begin
        if (!rst) begin
            while (q_ctl.size() > 0 && q_ctl[0].due <= cyc) begin
                mc = q_ctl.pop_front();
                check("rom_en",    32'(rom_en_o),    32'(mc.rom_en));
                check("rom_addr",  32'(rom_addr_o),  32'(mc.addr));
                check("frame",     32'(frame_o),     32'(mc.frame));
                check("busy",      32'(busy_o),      32'(mc.busy));
                check("anim_done", 32'(anim_done_o), 32'(mc.done));
            end
            while (q_pix.size() > 0 && q_pix[0].due <= cyc) begin
                mp = q_pix.pop_front();
                check("vga_rgb",   32'(vga_rgb_o),   32'(mp.rgb));
                check("vga_alpha", 32'(vga_alpha_o), 32'(mp.alpha));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached (%0d checks, %0d failures)", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk_vga);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        m_vs_prev = 1'b1;

        // Position (100,200), corner and just-outside requests
        nx_en = 1'b1; nx_xpos = 10'd100; nx_ypos = 10'd200; nx_mode = 2'b00;
        step(1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 100, 200);
        step(1'b1, 1'b0, 163, 263);
        step(1'b1, 1'b0, 164, 200);
        step(1'b1, 1'b0, 99, 200);
        step(1'b1, 1'b0, 100, 264);
        nx_xpos = 10'd500;
        step(1'b1, 1'b0, 100, 200);
        step(1'b1, 1'b0, 500, 200);
        vframe(32, -1);

        // Static frames (modes 00 and 11) with random positions, incl. screen edges
        for (int f = 0; f < 12; f++) begin
            nx_mode = (f % 2 == 0) ? 2'b00 : 2'b11;
            vframe(32, -1);
        end

        // Looping animation, with a blink window and an enable drop
        nx_mode = 2'b01;
        for (int f = 0; f < 14; f++) begin
            nx_blink = (f >= 4 && f < 11);
            vframe(32, -1);
        end
        nx_en = 1'b0;
        vframe(16, -1);
        nx_en = 1'b1;
        vframe(32, -1);
        vframe(32, -1);
        nx_mode = 2'b00;
        vframe(32, -1);
        vframe(32, -1);

        // One-shot: start, ignored starts during RUN and DONE, start on a tick, abort
        nx_mode = 2'b10;
        vframe(32, -1);
        vframe(32, 5);
        for (int f = 1; f < 8; f++) vframe(32, (f == 4) ? 9 : -1);
        vframe(32, 1);
        vframe(32, -1);
        vframe(32, 0);
        vframe(32, -1);
        vframe(32, -1);
        nx_mode = 2'b00;
        vframe(32, -1);
        vframe(32, -1);

        // Reset while a one-shot is running
        nx_mode = 2'b10;
        vframe(32, -1);
        vframe(32, 4);
        vframe(32, -1);
        vframe(32, -1);
        vframe(12, -1);
        do_reset();
        nx_mode = 2'b01;
        for (int f = 0; f < 4; f++) vframe(32, -1);
        repeat (3) step(1'b1, 1'b0, 0, 0);
        @(negedge clk_vga);
        @(negedge clk_vga);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
